// File: rtl/line_burst_if.sv
// Cache-side request/response handshake plus the single-word backing-store bus.
// The engine takes the master modport because it masters the backing-store bus.
interface line_burst_if #(
  parameter int cache_line_size          = 16,
  parameter int backing_store_word_size  = 2,
  parameter int backing_store_word_count = 2**25
);
  localparam int wpl         = cache_line_size / backing_store_word_size;
  localparam int word_addr_w = $clog2(backing_store_word_count);
  localparam int line_addr_w = word_addr_w - $clog2(wpl);

  logic                                   req_valid;
  logic                                   req_ready;
  logic                                   req_write;
  logic [line_addr_w-1:0]                 req_line_addr;
  logic [8*cache_line_size-1:0]           req_wdata;
  logic                                   resp_valid;
  logic                                   resp_error;
  logic [8*cache_line_size-1:0]           resp_rdata;
  logic [word_addr_w-1:0]                 backing_store_address;
  logic                                   backing_store_we;
  logic                                   backing_store_re;
  logic [8*backing_store_word_size-1:0]   backing_store_wdata;
  logic                                   backing_store_drdy;
  logic [8*backing_store_word_size-1:0]   backing_store_rdata;

  modport master (
    input  req_valid, req_write, req_line_addr, req_wdata,
    input  backing_store_drdy, backing_store_rdata,
    output req_ready, resp_valid, resp_error, resp_rdata,
    output backing_store_address, backing_store_we, backing_store_re, backing_store_wdata
  );

  modport slave (
    output req_valid, req_write, req_line_addr, req_wdata,
    output backing_store_drdy, backing_store_rdata,
    input  req_ready, resp_valid, resp_error, resp_rdata,
    input  backing_store_address, backing_store_we, backing_store_re, backing_store_wdata
  );
endinterface

// File: rtl/line_burst_engine.sv
// Splits one cache-line fill or eviction into single-word backing-store accesses and
// reassembles fill data into a line, reporting completion or timeout with one pulse.
module line_burst_engine #(
  parameter int cache_line_size          = 16,
  parameter int backing_store_word_size  = 2,
  parameter int backing_store_word_count = 2**25,
  parameter int backing_store_latency    = 3
) (
  input logic          backing_clk,
  input logic          reset_n,
  line_burst_if.master bus
);
  localparam int wpl            = cache_line_size / backing_store_word_size;
  localparam int wpl_log        = $clog2(wpl);
  localparam int word_addr_w    = $clog2(backing_store_word_count);
  localparam int line_addr_w    = word_addr_w - wpl_log;
  localparam int word_w         = 8 * backing_store_word_size;
  localparam int line_w         = 8 * cache_line_size;
  localparam int timeout_cycles = backing_store_latency + wpl + 8;
  localparam int cnt_w          = $clog2(wpl + 1);
  localparam int tmo_w          = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_ISSUE,
    READ_ISSUE,
    READ_COLLECT,
    RESPOND
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   active_q;
  logic [line_addr_w-1:0] line_q;
  logic [line_w-1:0]      wdata_q;
  logic [line_w-1:0]      buf_q;
  logic [cnt_w-1:0]       issue_idx_q;
  logic [cnt_w-1:0]       collect_idx_q;
  logic [tmo_w-1:0]       wait_q;
  logic                   error_q;

  logic                   accept;
  logic                   reading;
  logic                   sample;
  logic                   collect_done;
  logic                   timeout_hit;
  logic                   last_issue;
  logic [word_addr_w-1:0] word_addr;

  assign accept       = (state_q == IDLE) && active_q && bus.req_valid;
  assign reading      = (state_q == READ_ISSUE) || (state_q == READ_COLLECT);
  assign sample       = reading && bus.backing_store_drdy;
  assign collect_done = sample && (collect_idx_q == cnt_w'(wpl - 1));
  assign last_issue   = (issue_idx_q == cnt_w'(wpl - 1));
  assign word_addr    = (word_addr_w'(line_q) << wpl_log) | word_addr_w'(issue_idx_q);

  // wait_q holds the silent cycles already elapsed since the last word (or acceptance);
  // firing on the (timeout_cycles-1)th one puts resp_valid timeout_cycles after that anchor.
  assign timeout_hit  = reading && !bus.backing_store_drdy &&
                        (wait_q == tmo_w'(timeout_cycles - 2));

  always_ff @(posedge backing_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d                   = state_q;
    bus.req_ready             = 1'b0;
    bus.resp_valid            = 1'b0;
    bus.backing_store_we      = 1'b0;
    bus.backing_store_re      = 1'b0;
    bus.backing_store_address = '0;
    bus.backing_store_wdata   = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = active_q;
        if (accept) begin
          state_d = bus.req_write ? WRITE_ISSUE : READ_ISSUE;
        end
      end
      WRITE_ISSUE: begin
        bus.backing_store_we      = 1'b1;
        bus.backing_store_address = word_addr;
        bus.backing_store_wdata   = wdata_q[int'(issue_idx_q)*word_w +: word_w];
        if (last_issue) begin
          state_d = RESPOND;
        end
      end
      READ_ISSUE: begin
        bus.backing_store_re      = 1'b1;
        bus.backing_store_address = word_addr;
        if (collect_done || timeout_hit) begin
          state_d = RESPOND;
        end else if (last_issue) begin
          state_d = READ_COLLECT;
        end
      end
      READ_COLLECT: begin
        if (collect_done || timeout_hit) begin
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        bus.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // active_q keeps req_ready low while reset is held and for the cycle it is released in.
  always_ff @(posedge backing_clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q      <= 1'b0;
      line_q        <= '0;
      wdata_q       <= '0;
      buf_q         <= '0;
      issue_idx_q   <= '0;
      collect_idx_q <= '0;
      wait_q        <= '0;
      error_q       <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (accept) begin
        line_q        <= bus.req_line_addr;
        wdata_q       <= bus.req_wdata;
        buf_q         <= '0;
        issue_idx_q   <= '0;
        collect_idx_q <= '0;
        wait_q        <= '0;
        error_q       <= 1'b0;
      end else begin
        if ((state_q == WRITE_ISSUE) || (state_q == READ_ISSUE)) begin
          issue_idx_q <= issue_idx_q + cnt_w'(1);
        end
        if (sample) begin
          buf_q[int'(collect_idx_q)*word_w +: word_w] <= bus.backing_store_rdata;
          collect_idx_q <= collect_idx_q + cnt_w'(1);
          wait_q        <= '0;
        end else if (reading) begin
          wait_q <= wait_q + tmo_w'(1);
        end
        if (timeout_hit) begin
          error_q <= 1'b1;
        end
      end
    end
  end

  assign bus.resp_error = (state_q == RESPOND) && error_q;
  assign bus.resp_rdata = buf_q;
endmodule

// File: tb/tb_line_burst_engine.sv
// Randomized bench for line_burst_engine: each transaction's expected strobes, timing and
// assembled line come from a cycle-offset model of the drdy schedule the bench itself drives.
module tb_line_burst_engine;
  localparam int WPL         = 8;
  localparam int WORD_W      = 16;
  localparam int LINE_W      = 128;
  localparam int LINE_ADDR_W = 22;
  localparam int TIMEOUT     = 3 + WPL + 8;
  localparam int HORIZON     = 100;

  logic backing_clk = 1'b0;
  logic reset_n     = 1'b0;

  line_burst_if bus ();

  line_burst_engine dut (
    .backing_clk (backing_clk),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  always #5 backing_clk = ~backing_clk;

  int vectors     = 0;
  int miscompares = 0;
  int txn_id      = 0;

  bit              drdy_at  [HORIZON];
  logic [15:0]     rdata_at [HORIZON];

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] actual,
                             input logic [LINE_W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Offset-level model: resp one cycle after the last needed word, or TIMEOUT cycles after
  // the most recent word (acceptance counts as offset 0) when data stops arriving.
  function automatic void modelRead(output int resp_at, output bit err,
                                    output logic [LINE_W-1:0] line);
    int words  = 0;
    int anchor = 0;
    line    = '0;
    err     = 1'b0;
    resp_at = HORIZON - 2;
    for (int k = 1; k < HORIZON - 2; k++) begin
      if (drdy_at[k]) begin
        line[words*WORD_W +: WORD_W] = rdata_at[k];
        words++;
        anchor = k;
        if (words == WPL) begin
          resp_at = k + 1;
          return;
        end
      end else if (k + 1 - anchor == TIMEOUT) begin
        resp_at = k + 1;
        err     = 1'b1;
        return;
      end
    end
  endfunction

  task automatic buildSchedule(input int mode, input int nwords, input bit seq);
    int off;
    for (int k = 0; k < HORIZON; k++) begin
      drdy_at[k]  = 1'b0;
      rdata_at[k] = 16'($urandom);
    end
    off = (mode == 4) ? 1 : ((mode == 2) ? $urandom_range(2, 5) : 4);
    for (int w = 0; w < nwords && off < 56; w++) begin
      drdy_at[off]  = 1'b1;
      rdata_at[off] = seq ? (16'hB000 + 16'(w)) : 16'($urandom);
      case (mode)
        1:       off += 2;
        2:       off += $urandom_range(1, 4);
        3:       off += $urandom_range(1, 24);
        default: off += 1;
      endcase
    end
  endtask

  task automatic idleCycles(input int n);
    bus.req_valid          = 1'b0;
    bus.backing_store_drdy = 1'b0;
    repeat (n) begin
      @(negedge backing_clk);
      checkOutput("idle", LINE_W'({bus.resp_valid, bus.backing_store_we,
                                   bus.backing_store_re, bus.req_ready}), LINE_W'(4'b0001));
    end
  endtask

  // Starts and ends on a falling edge; the final check is the IDLE cycle after the response.
  task automatic applyStimulus(input bit is_write, input logic [LINE_ADDR_W-1:0] line,
                               input logic [LINE_W-1:0] wdata, input bit hold);
    int R;
    int waited = 0;
    bit err;
    bit exp_we;
    bit exp_re;
    logic [LINE_W-1:0] exp_line;
    txn_id++;
    bus.req_valid     = 1'b1;
    bus.req_write     = is_write;
    bus.req_line_addr = line;
    bus.req_wdata     = wdata;
    while (bus.req_ready !== 1'b1 && waited < 4) begin
      @(negedge backing_clk);
      waited++;
    end
    checkOutput($sformatf("t%0d accept", txn_id), LINE_W'(bus.req_ready), LINE_W'(1));
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      return;
    end
    if (is_write) begin
      R        = WPL + 1;
      err      = 1'b0;
      exp_line = '0;
    end else begin
      modelRead(R, err, exp_line);
      if (err) begin
        drdy_at[R]     = 1'b1;
        drdy_at[R + 1] = 1'b1;
      end
    end
    @(posedge backing_clk);
    for (int k = 1; k <= R; k++) begin
      @(negedge backing_clk);
      exp_we = is_write && (k <= WPL);
      exp_re = !is_write && (k <= WPL) && (k < R);
      checkOutput($sformatf("t%0d k%0d strobes", txn_id, k),
                  LINE_W'({bus.backing_store_we, bus.backing_store_re, bus.resp_valid, bus.req_ready}),
                  LINE_W'({exp_we, exp_re, (k == R), 1'b0}));
      if (exp_we || exp_re) begin
        checkOutput($sformatf("t%0d k%0d addr", txn_id, k),
                    LINE_W'(bus.backing_store_address), LINE_W'({line, 3'(k - 1)}));
      end
      if (exp_we) begin
        checkOutput($sformatf("t%0d k%0d wdata", txn_id, k),
                    LINE_W'(bus.backing_store_wdata), LINE_W'(wdata[(k-1)*WORD_W +: WORD_W]));
      end
      if (k == R) begin
        checkOutput($sformatf("t%0d error", txn_id), LINE_W'(bus.resp_error), LINE_W'(err));
        if (!is_write) begin
          checkOutput($sformatf("t%0d rdata", txn_id), bus.resp_rdata, exp_line);
        end
      end
      bus.backing_store_drdy  = is_write ? 1'($urandom) : drdy_at[k];
      bus.backing_store_rdata = is_write ? 16'($urandom) : rdata_at[k];
      if (k == 1) begin
        bus.req_valid = hold;
        if (hold) begin
          bus.req_write     = 1'($urandom);
          bus.req_line_addr = LINE_ADDR_W'($urandom);
          bus.req_wdata     = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
    @(negedge backing_clk);
    checkOutput($sformatf("t%0d ready back", txn_id),
                LINE_W'({bus.resp_valid, bus.req_ready}), LINE_W'(2'b01));
    bus.backing_store_drdy = is_write ? 1'b0 : drdy_at[R + 1];
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ctl"}, LINE_W'({bus.req_ready, bus.resp_valid, bus.resp_error,
                                        bus.backing_store_we, bus.backing_store_re}), '0);
    checkOutput({tag, " addr"}, LINE_W'(bus.backing_store_address), '0);
    checkOutput({tag, " wdata"}, LINE_W'(bus.backing_store_wdata), '0);
    checkOutput({tag, " rdata"}, bus.resp_rdata, '0);
  endtask

  task automatic resetMidWrite();
    bus.req_valid     = 1'b1;
    bus.req_write     = 1'b1;
    bus.req_line_addr = 22'h2A5;
    bus.req_wdata     = {$urandom, $urandom, $urandom, $urandom};
    checkOutput("rst ready", LINE_W'(bus.req_ready), LINE_W'(1));
    @(posedge backing_clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge backing_clk);
      bus.req_valid = 1'b0;
      checkOutput($sformatf("rst we k%0d", k), LINE_W'(bus.backing_store_we), LINE_W'(1));
    end
    reset_n = 1'b0;
    #1;
    checkAllZero("rst async");
    repeat (2) begin
      @(negedge backing_clk);
      checkAllZero("rst held");
    end
    reset_n = 1'b1;
    #1;
    checkOutput("rst release ready", LINE_W'(bus.req_ready), LINE_W'(0));
    @(negedge backing_clk);
    checkOutput("rst first edge ready", LINE_W'(bus.req_ready), LINE_W'(1));
    idleCycles(12);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LINE_W-1:0] wd;
    bus.req_valid           = 1'b0;
    bus.req_write           = 1'b0;
    bus.req_line_addr       = '0;
    bus.req_wdata           = '0;
    bus.backing_store_drdy  = 1'b0;
    bus.backing_store_rdata = '0;

    #2;
    checkAllZero("reset");
    @(negedge backing_clk);
    @(negedge backing_clk);
    reset_n = 1'b1;
    #1;
    checkOutput("release ready", LINE_W'(bus.req_ready), LINE_W'(0));
    @(negedge backing_clk);
    checkOutput("first edge ready", LINE_W'(bus.req_ready), LINE_W'(1));

    for (int i = 0; i < WPL; i++) wd[i*WORD_W +: WORD_W] = 16'hA000 + 16'(i);
    applyStimulus(1'b1, 22'h12, wd, 1'b0);

    buildSchedule(0, WPL, 1'b1);
    applyStimulus(1'b0, 22'h3, '0, 1'b0);

    buildSchedule(0, 5, 1'b1);
    applyStimulus(1'b0, 22'h7, '0, 1'b0);
    idleCycles(3);

    buildSchedule(1, WPL, 1'b1);
    applyStimulus(1'b0, 22'h55, '0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1'b1, LINE_ADDR_W'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      end else begin
        buildSchedule(2, WPL, 1'b0);
        applyStimulus(1'b0, LINE_ADDR_W'($urandom), '0, 1'b1);
      end
    end
    idleCycles(2);

    resetMidWrite();

    for (int n = 0; n < 40; n++) begin
      bit is_write;
      bit hold;
      int mode;
      is_write = 1'($urandom);
      hold     = 1'($urandom);
      if (is_write) begin
        applyStimulus(1'b1, LINE_ADDR_W'($urandom), {$urandom, $urandom, $urandom, $urandom}, hold);
      end else begin
        mode = $urandom_range(0, 4);
        buildSchedule(mode, (mode <= 1) ? $urandom_range(0, WPL) : WPL, 1'b0);
        applyStimulus(1'b0, LINE_ADDR_W'($urandom), '0, hold);
      end
      if (!hold || $urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end
    idleCycles(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
